// File: rtl/ram_init_pkg.sv
// ---------------------------------------------------------------------------
// ram_init_pkg
// Purpose : Shared types and default sizes for the single-port byte RAM
//           bus master (ram_initiator).
// Contents: state_t     - transaction FSM states
//           DEF_*       - default widths/depth used as module parameter
//                         defaults
// ---------------------------------------------------------------------------
package ram_init_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MEM_DEPTH = 8;
  localparam int DEF_CNT_W     = 16;

  // One transaction in flight: IDLE accepts, WR/RD_* touch the RAM pins,
  // RSP holds the response until the requester takes it.
  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_CAP,
    RSP
  } state_t;

endpackage : ram_init_pkg

// File: rtl/ram_initiator.sv
// ---------------------------------------------------------------------------
// ram_initiator
// Purpose : Bus master for a single-port byte RAM with an RWn/raddr/waddr/
//           wdata/rdata interface. Accepts one read or write request on a
//           valid/ready port, drives the RAM pins, captures read data and
//           returns exactly one response per request on a valid/ready port.
//
// Ports   : clk, rst                 clock, async active-high reset
//           req_valid/req_ready      request handshake
//           req_write/addr/wdata     request payload (1 = write)
//           rsp_valid/rsp_ready      response handshake
//           rsp_rdata/rsp_err        response payload (err = out of range)
//           RWn/raddr/waddr/wdata    RAM control/address/data (RWn 1 = read)
//           rdata                    RAM read data
//           wr_count/rd_count/       completed writes, completed reads and
//           err_count                rejected requests (wrap-around)
// ---------------------------------------------------------------------------
module ram_initiator
  import ram_init_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              RWn,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  err_count
);

  state_t             state_q,     state_d;
  logic               rwn_q,       rwn_d;
  logic [ADDR_W-1:0]  raddr_q,     raddr_d;
  logic [ADDR_W-1:0]  waddr_q,     waddr_d;
  logic [DATA_W-1:0]  wdata_q,     wdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]   wr_count_q,  wr_count_d;
  logic [CNT_W-1:0]   rd_count_q,  rd_count_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;

  logic addr_bad;

  // Compare at 32 bits so a depth equal to 2**ADDR_W does not wrap to zero.
  assign addr_bad = (32'(req_addr) >= 32'(MEM_DEPTH));

  // Next-state and next-output logic. Every register holds by default, so
  // the RAM address/data pins keep their last driven values while idle.
  always_comb begin
    state_d     = state_q;
    rwn_d       = rwn_q;
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wr_count_d  = wr_count_q;
    rd_count_d  = rd_count_q;
    err_count_d = err_count_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (addr_bad) begin
            // Rejected request: answer immediately, leave the RAM pins alone.
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            err_count_d = err_count_q + CNT_W'(1);
          end else if (req_write) begin
            state_d = WR;
            waddr_d = req_addr;
            wdata_d = req_wdata;
            rwn_d   = 1'b0;
          end else begin
            state_d = RD_ISSUE;
            raddr_d = req_addr;
          end
        end
      end

      WR: begin
        // The RAM commits the write on this edge; drop back to read mode.
        rwn_d       = 1'b1;
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        wr_count_d  = wr_count_q + CNT_W'(1);
      end

      RD_ISSUE: begin
        // RAM loads rdata on this edge; capturing it one cycle later avoids
        // racing the RAM's own update.
        state_d = RD_CAP;
      end

      RD_CAP: begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rdata;
        rd_count_d  = rd_count_q + CNT_W'(1);
      end

      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        rwn_d   = 1'b1;
      end
    endcase
  end

  // State and registered outputs. Reset is asynchronous so RWn returns to
  // read mode at once, aborting a write that has not yet reached its edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rwn_q       <= 1'b1;
      raddr_q     <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rwn_q       <= rwn_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign RWn       = rwn_q;
  assign raddr     = raddr_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;
  assign err_count = err_count_q;

endmodule : ram_initiator

// File: tb/tb_ram_initiator.sv
// ---------------------------------------------------------------------------
// tb_ram_initiator
// Directed bench for ram_initiator with a small behavioural byte RAM
// preloaded with 40,21,42,35,46,59,66,17.
// ---------------------------------------------------------------------------
module tb_ram_initiator;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        RWn;
  logic [7:0]  raddr;
  logic [7:0]  waddr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic [15:0] err_count;

  int checks   = 0;
  int failures = 0;
  int rwnLowCount = 0;

  logic [7:0] mem [0:7];

  ram_initiator dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .RWn       (RWn),
    .raddr     (raddr),
    .waddr     (waddr),
    .wdata     (wdata),
    .rdata     (rdata),
    .wr_count  (wr_count),
    .rd_count  (rd_count),
    .err_count (err_count)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: writes when RWn=0, otherwise reloads rdata from raddr.
  initial begin
    mem[0] = 8'd40; mem[1] = 8'd21; mem[2] = 8'd42; mem[3] = 8'd35;
    mem[4] = 8'd46; mem[5] = 8'd59; mem[6] = 8'd66; mem[7] = 8'd17;
    rdata  = 8'd0;
  end

  always @(posedge clk) begin
    if (RWn === 1'b0) begin
      if (waddr < 8'd8) mem[waddr[2:0]] <= wdata;
    end else begin
      rdata <= (raddr < 8'd8) ? mem[raddr[2:0]] : 8'd0;
    end
  end

  // Counts clock periods in which the RAM is held in write mode.
  always @(negedge clk) begin
    if (RWn === 1'b0) rwnLowCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Presents one request, lets it be accepted on the next edge, then waits
  // (bounded) for rsp_valid. lat counts edges from acceptance, inclusive.
  task automatic applyStimulus(input logic wr, input logic [7:0] addr,
                               input logic [7:0] data, output int lat);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Consumes the pending response (rsp_ready assumed high).
  task automatic finishResponse(input string tag);
    @(posedge clk); #1;
    checkOutput({tag, "_rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_req_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int lowBefore;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 8'd0;
    req_wdata = 8'd0;
    rsp_ready = 1'b1;

    // Reset, then idle five cycles.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    $display("[TB] reset/idle checks");
    checkOutput("rst_RWn",       32'(RWn),       32'd1);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    checkOutput("rst_wr_count",  32'(wr_count),  32'd0);
    checkOutput("rst_rd_count",  32'(rd_count),  32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    checkOutput("rst_raddr",     32'(raddr),     32'd0);

    // Read address 3.
    $display("[TB] read addr 3");
    applyStimulus(1'b0, 8'd3, 8'd0, lat);
    checkOutput("rd3_latency",  32'(lat),       32'd3);
    checkOutput("rd3_rdata",    32'(rsp_rdata), 32'd35);
    checkOutput("rd3_err",      32'(rsp_err),   32'd0);
    checkOutput("rd3_rd_count", 32'(rd_count),  32'd1);
    finishResponse("rd3");

    // Write address 5 with 8'hA5, then read it back.
    $display("[TB] write addr 5, read back");
    lowBefore = rwnLowCount;
    applyStimulus(1'b1, 8'd5, 8'hA5, lat);
    checkOutput("wr5_latency",  32'(lat),                     32'd2);
    checkOutput("wr5_rwn_low",  32'(rwnLowCount - lowBefore), 32'd1);
    checkOutput("wr5_RWn_back", 32'(RWn),                     32'd1);
    checkOutput("wr5_waddr",    32'(waddr),                   32'd5);
    checkOutput("wr5_wdata",    32'(wdata),                   32'hA5);
    checkOutput("wr5_rdata",    32'(rsp_rdata),               32'd0);
    checkOutput("wr5_err",      32'(rsp_err),                 32'd0);
    checkOutput("wr5_wr_count", 32'(wr_count),                32'd1);
    finishResponse("wr5");
    applyStimulus(1'b0, 8'd5, 8'd0, lat);
    checkOutput("rd5_latency",  32'(lat),       32'd3);
    checkOutput("rd5_rdata",    32'(rsp_rdata), 32'hA5);
    checkOutput("rd5_rd_count", 32'(rd_count),  32'd2);
    finishResponse("rd5");

    // Out-of-range read: immediate error, RAM pins untouched.
    $display("[TB] read addr 9 (out of range)");
    lowBefore = rwnLowCount;
    applyStimulus(1'b0, 8'd9, 8'd0, lat);
    checkOutput("rd9_latency",   32'(lat),                     32'd1);
    checkOutput("rd9_err",       32'(rsp_err),                 32'd1);
    checkOutput("rd9_rdata",     32'(rsp_rdata),               32'd0);
    checkOutput("rd9_raddr",     32'(raddr),                   32'd5);
    checkOutput("rd9_RWn",       32'(RWn),                     32'd1);
    checkOutput("rd9_rwn_low",   32'(rwnLowCount - lowBefore), 32'd0);
    checkOutput("rd9_err_count", 32'(err_count),               32'd1);
    finishResponse("rd9");

    // Back-pressured response on read of address 0.
    $display("[TB] read addr 0 with rsp_ready low");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 8'd0, 8'd0, lat);
    checkOutput("rd0_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rd0_hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("rd0_hold_rdata", 32'(rsp_rdata), 32'd40);
      checkOutput("rd0_hold_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    checkOutput("rd0_rd_count", 32'(rd_count), 32'd3);
    finishResponse("rd0");

    // Reset during the WR cycle of a write to address 2.
    $display("[TB] reset during write addr 2");
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'd2;
    req_wdata = 8'd99;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("wr2_in_wr_RWn", 32'(RWn), 32'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("wr2_rst_RWn",       32'(RWn),       32'd1);
    checkOutput("wr2_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("wr2_rst_rd_count",  32'(rd_count),  32'd0);
    checkOutput("wr2_rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("wr2_wr_count", 32'(wr_count), 32'd0);
    applyStimulus(1'b0, 8'd2, 8'd0, lat);
    checkOutput("rd2_latency",  32'(lat),       32'd3);
    checkOutput("rd2_rdata",    32'(rsp_rdata), 32'd42);
    checkOutput("rd2_rd_count", 32'(rd_count),  32'd1);
    finishResponse("rd2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ram_initiator
